// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the data memory (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    // Handshake: the master raises dmem_req and holds dmem_we/dmem_addr/dmem_wdata
    // stable until the slave pulses dmem_ack for one cycle; dmem_rdata is valid only
    // in that ack cycle, and an ack seen while dmem_req is low carries no meaning.
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results to WB, runs req/ack loads and stores with
// upstream stall. Optional ack timeout with sticky mem_err enabled by MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [37:0] pipeline_re_i,
    output logic [19:0] pipeline_ou,
    output logic        stall,
    mem_stage_if.master dmem,
    output logic [2:0]  mem_op_dest,
    output logic        mem_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] rdata_q;

    logic [15:0] alu_result;
    logic        mem_writ_en;
    logic [15:0] mem_writ_data;
    logic        wri_back_en;
    logic [2:0]  wri_back_dest;
    logic        wri_back_result_mux;
    logic        store;
    logic        load;
    logic        mem_op;
    logic        is_load;

    assign alu_result          = pipeline_re_i[37:22];
    assign mem_writ_en         = pipeline_re_i[21];
    assign mem_writ_data       = pipeline_re_i[20:5];
    assign wri_back_en         = pipeline_re_i[4];
    assign wri_back_dest       = pipeline_re_i[3:1];
    assign wri_back_result_mux = pipeline_re_i[0];

    assign store   = mem_writ_en;
    assign load    = wri_back_en & wri_back_result_mux;
    assign mem_op  = store | load;
    // A store that also looks like a load is treated as a store with no write-back.
    assign is_load = load & ~store;

    // Stall is also gated by reset so upstream is released the moment reset asserts.
    assign stall       = rst_n & mem_op & (state != DONE);
    assign mem_op_dest = wri_back_dest;
    assign dbg_state   = state;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
`else
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pipeline_ou     <= '0;
            rdata_q         <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt        <= '0;
            mem_err         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        dmem.dmem_we    <= store;
                        dmem.dmem_addr  <= alu_result[ADDR_W-1:0];
                        dmem.dmem_wdata <= mem_writ_data;
                        dmem.dmem_req   <= 1'b1;
                        pipeline_ou     <= '0;
                        state           <= REQ;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt        <= '0;
`endif
                    end else begin
                        pipeline_ou <= {alu_result, wri_back_en, wri_back_dest};
                    end
                end
                REQ: begin
                    pipeline_ou <= '0;
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req <= 1'b0;
                        if (is_load) rdata_q <= dmem.dmem_rdata;
                        state <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    // Give up after TIMEOUT request cycles; an abandoned load returns a marker.
                    else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        dmem.dmem_req <= 1'b0;
                        mem_err       <= 1'b1;
                        if (is_load) rdata_q <= DATA_W'(16'hDEAD);
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    if (is_load) pipeline_ou <= {rdata_q, 1'b1, wri_back_dest};
                    else         pipeline_ou <= {alu_result, 1'b0, wri_back_dest};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
